// File: rtl/pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
// into STAGES slices of CHUNK bits. Each slice is resolved in one cycle from
// 4-bit CLA blocks with group lookahead, and the slice carry is registered
// into the next stage. Operand bits not yet consumed travel forward with the
// pipeline, and completed sum bits ride along so every slice lines up in the
// final stage register, which drives the outputs directly.
//
// A single global stall (adv) freezes every stage when the output holds a
// result the consumer has not taken. Latency is STAGES cycles and throughput
// is one result per cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  input accepted this cycle (= !out_valid | out_ready)
//   a, b       in   operands, WIDTH bits
//   c_in       in   carry-in (add) / borrow-in (sub)
//   sub        in   0: a + b + c_in, 1: a - b - c_in
//   out_valid  out  result fields valid
//   out_ready  in   consumer takes the result
//   sum        out  result, WIDTH bits
//   c_out      out  carry out of the MSB (sub: 1 = no borrow)
//   ovf        out  signed overflow
//   prop       out  word propagate, AND of all (a ^ b_eff)
//   gen        out  word generate, MSB carry with carry0 forced to 0
// ----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             prop,
    output logic             gen
);

    localparam int STAGES    = int'(WIDTH / CHUNK);
    localparam int GROUPS    = int'(CHUNK / 4);
    localparam int LAST      = STAGES - 1;
    // Operand skew registers feed stages 1..LAST; the last stage needs none.
    localparam int SKEWDEPTH = (STAGES > 1) ? STAGES - 1 : 1;

    // 4-bit carry-lookahead block. Returns {group P, group G, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       pg;
        logic       gg;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {pg, gg, p ^ c};
    endfunction

    logic                             adv;
    logic [WIDTH-1:0]                 b_eff;
    logic                             carry0;

    logic [STAGES-1:0]                vld_q,  vld_d;
    logic [STAGES-1:0][WIDTH-1:0]     sum_q,  sum_d;
    logic [STAGES-1:0]                cy_q,   cy_d;   // real carry out of each slice
    logic [STAGES-1:0]                pw_q,   pw_d;   // running word propagate
    logic [STAGES-1:0]                gw_q,   gw_d;   // running word generate (carry0 = 0)
    logic [SKEWDEPTH-1:0][WIDTH-1:0]  a_q,    a_d;
    logic [SKEWDEPTH-1:0][WIDTH-1:0]  b_q,    b_d;    // already conditioned (b_eff)
    logic                             ovf_q,  ovf_d;

    assign out_valid = vld_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    assign b_eff  = sub ? ~b : b;
    assign carry0 = sub ? ~c_in : c_in;

    always_comb begin
        int               pk;
        logic [WIDTH-1:0] a_cur;
        logic [WIDTH-1:0] b_cur;
        logic [WIDTH-1:0] s_cur;
        logic             c;
        logic             p_prev;
        logic             g_prev;
        logic             sp;
        logic             sg;
        logic [5:0]       r;

        vld_d  = '0;
        sum_d  = '0;
        cy_d   = '0;
        pw_d   = '0;
        gw_d   = '0;
        a_d    = '0;
        b_d    = '0;
        ovf_d  = 1'b0;
        pk     = 0;
        a_cur  = '0;
        b_cur  = '0;
        s_cur  = '0;
        c      = 1'b0;
        p_prev = 1'b0;
        g_prev = 1'b0;
        sp     = 1'b0;
        sg     = 1'b0;
        r      = '0;

        for (int k = 0; k < STAGES; k++) begin
            pk     = (k == 0) ? 0 : k - 1;
            vld_d[k] = (k == 0) ? in_valid : vld_q[pk];
            a_cur  = (k == 0) ? a      : a_q[pk];
            b_cur  = (k == 0) ? b_eff  : b_q[pk];
            c      = (k == 0) ? carry0 : cy_q[pk];
            s_cur  = (k == 0) ? '0     : sum_q[pk];
            p_prev = (k == 0) ? 1'b1   : pw_q[pk];
            g_prev = (k == 0) ? 1'b0   : gw_q[pk];

            // Group lookahead across the slice: carry, slice P and slice G
            // (the latter with the slice carry-in forced to 0).
            sp = 1'b1;
            sg = 1'b0;
            for (int j = 0; j < GROUPS; j++) begin
                r = cla4(a_cur[k*CHUNK + j*4 +: 4], b_cur[k*CHUNK + j*4 +: 4], c);
                s_cur[k*CHUNK + j*4 +: 4] = r[3:0];
                c  = r[4] | (r[5] & c);
                sg = r[4] | (r[5] & sg);
                sp = sp & r[5];
            end

            sum_d[k] = s_cur;
            cy_d[k]  = c;
            pw_d[k]  = p_prev & sp;
            gw_d[k]  = sg | (sp & g_prev);

            if (k == LAST) begin
                ovf_d = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) &&
                        (s_cur[WIDTH-1] != a_cur[WIDTH-1]);
            end
        end

        for (int k = 0; k < SKEWDEPTH; k++) begin
            pk     = (k == 0) ? 0 : k - 1;
            a_d[k] = (k == 0) ? a     : a_q[pk];
            b_d[k] = (k == 0) ? b_eff : b_q[pk];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sum_q <= '0;
            cy_q  <= '0;
            pw_q  <= '0;
            gw_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            sum_q <= sum_d;
            cy_q  <= cy_d;
            pw_q  <= pw_d;
            gw_q  <= gw_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum   = sum_q[LAST];
    assign c_out = cy_q[LAST];
    assign prop  = pw_q[LAST];
    assign gen   = gw_q[LAST];
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        prop;
    logic        gen;

    pipelined_cla_adder #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .prop      (prop),
        .gen       (gen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        p;
        logic        g;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    res_t exp_q[$];

    // Reference: plain arithmetic on the conditioned operands.
    function automatic res_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb);
        logic [31:0] be;
        logic        c0;
        logic [32:0] full;
        logic [32:0] nc;
        res_t        r;
        be   = sb ? ~bv : bv;
        c0   = sb ? ~ci : ci;
        full = {1'b0, av} + {1'b0, be} + {32'd0, c0};
        nc   = {1'b0, av} + {1'b0, be};
        r.s  = full[31:0];
        r.co = full[32];
        r.p  = &(av ^ be);
        r.g  = nc[32];
        r.ov = (av[31] == be[31]) && (full[31] != av[31]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, checks the head result and handshake rule.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("sum",   sum,            e.s);
                        chk("c_out", {31'd0, c_out}, {31'd0, e.co});
                        chk("ovf",   {31'd0, ovf},   {31'd0, e.ov});
                        chk("prop",  {31'd0, prop},  {31'd0, e.p});
                        chk("gen",   {31'd0, gen},   {31'd0, e.g});
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
            end
        end
    end

    // One op into an empty pipe; checks latency and literal results.
    task automatic run_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic ci, input logic sb, input logic [31:0] es,
                           input logic eco, input logic eov, input logic ep, input logic eg);
        @(posedge clk);
        #1;
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk({nm, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            end else begin
                chk({nm, "_lat_valid"}, {31'd0, out_valid}, 32'd1);
                chk({nm, "_sum"},   sum,            es);
                chk({nm, "_c_out"}, {31'd0, c_out}, {31'd0, eco});
                chk({nm, "_ovf"},   {31'd0, ovf},   {31'd0, eov});
                chk({nm, "_prop"},  {31'd0, prop},  {31'd0, ep});
                chk({nm, "_gen"},   {31'd0, gen},   {31'd0, eg});
            end
        end
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic        vs [8];

    initial begin
        int idx;
        int t;
        int base;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vc[0] = 1'b0; vs[0] = 1'b0;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = 32'h0000_0000; vb[2] = 32'h0000_0001; vc[2] = 1'b0; vs[2] = 1'b1;
        va[3] = 32'hDEAD_BEEF; vb[3] = 32'h1234_5678; vc[3] = 1'b1; vs[3] = 1'b0;
        va[4] = 32'h0000_00FF; vb[4] = 32'h0000_0001; vc[4] = 1'b0; vs[4] = 1'b0;
        va[5] = 32'h8000_0000; vb[5] = 32'h8000_0000; vc[5] = 1'b0; vs[5] = 1'b0;
        va[6] = 32'h1234_5678; vb[6] = 32'h1234_5678; vc[6] = 1'b1; vs[6] = 1'b1;
        va[7] = 32'h00FF_FF00; vb[7] = 32'h0000_0100; vc[7] = 1'b0; vs[7] = 1'b0;

        // Reset state.
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum",       sum,                32'd0);
        chk("rst_flags",     {27'd0, c_out, ovf, prop, gen, 1'b0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors with hand-computed results.
        run_one("t1", 32'h0000_0004, 32'h0000_0009, 1'b0, 1'b0, 32'h0000_000D, 0, 0, 0, 0);
        run_one("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 0, 1);
        run_one("t3", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
        run_one("t4a", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        run_one("t4b", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 1);

        // Eight back-to-back ops with a three-cycle consumer stall.
        repeat (2) @(posedge clk);
        base = n_out;
        idx  = 0;
        t    = 0;
        while (idx < 8 && t < 100) begin
            @(posedge clk);
            #1;
            a = va[idx]; b = vb[idx]; c_in = vc[idx]; sub = vs[idx]; in_valid = 1'b1;
            out_ready = !(t >= 5 && t <= 7);
            @(negedge clk);
            if (t >= 5 && t <= 7) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (in_ready) idx++;
            t++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while ((n_out - base) < 8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("burst_count", n_out - base, 32'd8);
        chk("burst_drained", exp_q.size(), 32'd0);

        // Reset with ops in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'h1000_0000 * (i + 1); b = 32'h0000_0003; c_in = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum",   sum,                32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        run_one("t6", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_no_extra", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
